// File: rtl/lz_pkg.sv
// rtl/lz_pkg.sv - shared defaults, types and window state for the LZRW1 history window
package lz_pkg;

    localparam int DEF_HIST_DEPTH = 4096;
    localparam int DEF_MAX_MATCH  = 16;
    localparam int DEF_HASH_BYTES = 3;
    localparam int DEF_POS_W      = $clog2(DEF_HIST_DEPTH);
    localparam int DEF_LEN_W      = $clog2(DEF_MAX_MATCH + 1);

    typedef logic [DEF_POS_W-1:0] pos_t;
    typedef logic [DEF_LEN_W-1:0] len_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } win_state_e;

endpackage

// File: rtl/history_window_if.sv
// rtl/history_window_if.sv - byte source, hash, match query and advance signals of the history window
interface history_window_if
    import lz_pkg::*;
#(
    parameter int POS_W      = DEF_POS_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int HASH_BYTES = DEF_HASH_BYTES
);

    logic                    in_valid;
    logic                    in_ready;
    logic [7:0]              in_byte;
    logic                    in_last;

    logic                    hash_valid;
    logic [8*HASH_BYTES-1:0] hash_key;
    logic [POS_W-1:0]        hash_pos;

    logic                    cmp_req;
    logic [POS_W-1:0]        cmp_offset;
    logic                    cmp_valid;
    logic [LEN_W-1:0]        cmp_len;
    logic                    cmp_err;

    logic                    adv_valid;
    logic [LEN_W-1:0]        adv_len;
    logic                    adv_err;

    logic [LEN_W-1:0]        look_cnt;
    logic                    done;

    modport master (
        output in_valid, in_byte, in_last, cmp_req, cmp_offset, adv_valid, adv_len,
        input  in_ready, hash_valid, hash_key, hash_pos, cmp_valid, cmp_len, cmp_err,
               adv_err, look_cnt, done
    );

    modport slave (
        input  in_valid, in_byte, in_last, cmp_req, cmp_offset, adv_valid, adv_len,
        output in_ready, hash_valid, hash_key, hash_pos, cmp_valid, cmp_len, cmp_err,
               adv_err, look_cnt, done
    );

endinterface

// File: rtl/match_len_cmp.sv
// rtl/match_len_cmp.sv - leading-equal-byte count of two byte vectors, bounded by a limit
module match_len_cmp
    import lz_pkg::*;
#(
    parameter int MAX_MATCH = DEF_MAX_MATCH,
    parameter int LEN_W     = $clog2(MAX_MATCH + 1)
) (
    input  logic [8*MAX_MATCH-1:0] cur_bytes,
    input  logic [8*MAX_MATCH-1:0] cand_bytes,
    input  logic [LEN_W-1:0]       limit,
    output logic [LEN_W-1:0]       len
);

    // Byte i sits at bits [8*i +: 8]; run[i+1] holds while bytes 0..i all match.
    logic [MAX_MATCH-1:0] hit;
    logic [MAX_MATCH:0]   run;

    always_comb begin
        hit = '0;
        for (int i = 0; i < MAX_MATCH; i++) begin
            hit[i] = (cur_bytes[8*i +: 8] == cand_bytes[8*i +: 8]) && (LEN_W'(i) < limit);
        end
    end

    always_comb begin
        run    = '0;
        run[0] = 1'b1;
        len    = '0;
        for (int i = 0; i < MAX_MATCH; i++) begin
            run[i+1] = run[i] & hit[i];
            len      = len + LEN_W'(run[i+1]);
        end
    end

endmodule

// File: rtl/history_window.sv
// rtl/history_window.sv - circular history/lookahead buffer with hash key and match-length queries
module history_window
    import lz_pkg::*;
#(
    parameter int HIST_DEPTH = DEF_HIST_DEPTH,
    parameter int MAX_MATCH  = DEF_MAX_MATCH,
    parameter int HASH_BYTES = DEF_HASH_BYTES
) (
    input logic              clock,
    input logic              reset,
    history_window_if.slave  bus
);

    localparam int POS_W = $clog2(HIST_DEPTH);
    localparam int LEN_W = $clog2(MAX_MATCH + 1);

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_MATCH);
    localparam logic [LEN_W-1:0] HASH_LEN = LEN_W'(HASH_BYTES);
    localparam logic [POS_W:0]   HIST_MAX = (POS_W + 1)'(HIST_DEPTH - MAX_MATCH);

    logic [7:0]              mem [HIST_DEPTH];

    logic [POS_W-1:0]        wr_ptr;
    logic [POS_W-1:0]        cur;
    logic [POS_W-1:0]        hist_cnt;
    win_state_e              state_q;
    win_state_e              state_d;

    logic [LEN_W-1:0]        look;
    logic                    in_ready;
    logic                    wr_en;
    logic                    adv_ok;
    logic                    cmp_illegal;
    logic [POS_W-1:0]        cand_base;
    logic [POS_W:0]          hist_sum;

    logic [8*MAX_MATCH-1:0]  cur_bytes;
    logic [8*MAX_MATCH-1:0]  cand_bytes;
    logic [LEN_W-1:0]        match_len;
    logic [8*HASH_BYTES-1:0] hash_bytes;
    logic                    hash_valid;

    logic                    cmp_valid_q;
    logic [LEN_W-1:0]        cmp_len_q;
    logic                    cmp_err_q;
    logic                    adv_err_q;

    assign look        = LEN_W'(wr_ptr - cur);
    assign in_ready    = !reset && (state_q == RUN) && (look < MAX_LEN);
    assign wr_en       = bus.in_valid && in_ready;
    assign adv_ok      = bus.adv_valid && (bus.adv_len != '0) && (bus.adv_len <= look);
    assign cmp_illegal = (bus.cmp_offset == '0) || (bus.cmp_offset > hist_cnt);
    assign cand_base   = cur - bus.cmp_offset;
    assign hist_sum    = {1'b0, hist_cnt} + (POS_W + 1)'(bus.adv_len);

    // Candidate bytes past cur (overlapping matches) come straight from the lookahead.
    always_comb begin
        cur_bytes  = '0;
        cand_bytes = '0;
        for (int i = 0; i < MAX_MATCH; i++) begin
            cur_bytes[8*i +: 8]  = mem[cur + POS_W'(i)];
            cand_bytes[8*i +: 8] = mem[cand_base + POS_W'(i)];
        end
    end

    always_comb begin
        hash_bytes = '0;
        for (int i = 0; i < HASH_BYTES; i++) begin
            hash_bytes[8*(HASH_BYTES-1-i) +: 8] = cur_bytes[8*i +: 8];
        end
    end

    assign hash_valid = (look >= HASH_LEN);

    match_len_cmp #(
        .MAX_MATCH (MAX_MATCH),
        .LEN_W     (LEN_W)
    ) u_match_len_cmp (
        .cur_bytes  (cur_bytes),
        .cand_bytes (cand_bytes),
        .limit      (look),
        .len        (match_len)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (wr_en && bus.in_last) state_d = DRAIN;
            DRAIN:   if (look == '0)           state_d = DONE;
            DONE:                              state_d = RUN;
            default:                           state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.in_byte;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wr_ptr      <= '0;
            cur         <= '0;
            hist_cnt    <= '0;
            cmp_valid_q <= 1'b0;
            cmp_len_q   <= '0;
            cmp_err_q   <= 1'b0;
            adv_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (adv_ok) begin
                cur <= cur + POS_W'(bus.adv_len);
            end
            // A finished stream leaves its bytes in the ring but out of reach of any query.
            if (state_q == DONE) begin
                hist_cnt <= '0;
            end else if (adv_ok) begin
                hist_cnt <= (hist_sum > HIST_MAX) ? POS_W'(HIST_MAX) : POS_W'(hist_sum);
            end
            cmp_valid_q <= bus.cmp_req;
            cmp_len_q   <= (bus.cmp_req && !cmp_illegal) ? match_len : '0;
            cmp_err_q   <= bus.cmp_req && cmp_illegal;
            adv_err_q   <= bus.adv_valid && !adv_ok;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.hash_valid = hash_valid;
    assign bus.hash_key   = hash_valid ? hash_bytes : '0;
    assign bus.hash_pos   = cur;
    assign bus.cmp_valid  = cmp_valid_q;
    assign bus.cmp_len    = cmp_len_q;
    assign bus.cmp_err    = cmp_err_q;
    assign bus.adv_err    = adv_err_q;
    assign bus.look_cnt   = look;
    assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_history_window.sv
// tb/tb_history_window.sv - randomized self-checking bench for history_window against a stream model
module tb_history_window;

    localparam int HD   = 4096;
    localparam int MM   = 16;
    localparam int HB   = 3;
    localparam int HMAX = HD - MM;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    history_window_if bus();

    history_window dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: the whole stream by absolute position, plus absolute cursors.
    logic [7:0] hist [int];
    int         m_wr;
    int         m_cur;
    int         m_hist;
    int         m_phase;
    logic       e_cv;
    logic [4:0] e_cl;
    logic       e_ce;
    logic       e_ae;
    logic [7:0] pattern [HD];

    function automatic int m_look();
        return m_wr - m_cur;
    endfunction

    function automatic logic [23:0] m_key();
        if (m_look() >= HB) return {hist[m_cur], hist[m_cur+1], hist[m_cur+2]};
        return 24'h0;
    endfunction

    function automatic logic [51:0] exp_all();
        int lk;
        lk = m_look();
        return {(m_phase == 0 && lk < MM), (lk >= HB), m_key(), 12'(m_cur % HD),
                e_cv, e_cl, e_ce, e_ae, 5'(lk), (m_phase == 2)};
    endfunction

    function automatic logic [51:0] obs_all();
        return {bus.in_ready, bus.hash_valid, bus.hash_key, bus.hash_pos,
                bus.cmp_valid, bus.cmp_len, bus.cmp_err, bus.adv_err, bus.look_cnt, bus.done};
    endfunction

    task automatic m_reset();
        hist.delete();
        m_wr = 0; m_cur = 0; m_hist = 0; m_phase = 0;
        e_cv = 0; e_cl = '0; e_ce = 0; e_ae = 0;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_byte = '0; bus.in_last = 0;
        bus.cmp_req = 0; bus.cmp_offset = '0;
        bus.adv_valid = 0; bus.adv_len = '0;
    endtask

    // Apply the current inputs for one clock and advance the model by the same rules.
    task automatic tick();
        int  look, off, n;
        bit  rdy, acc, aok;
        look = m_look();
        rdy  = (m_phase == 0) && (look < MM);
        acc  = bus.in_valid && rdy;
        e_cv = bus.cmp_req; e_cl = '0; e_ce = 0;
        if (bus.cmp_req) begin
            off = int'(bus.cmp_offset);
            if (off == 0 || off > m_hist) e_ce = 1;
            else begin
                n = 0;
                while (n < look && n < MM && hist[m_cur - off + n] === hist[m_cur + n]) n++;
                e_cl = 5'(n);
            end
        end
        aok  = bus.adv_valid && int'(bus.adv_len) >= 1 && int'(bus.adv_len) <= look;
        e_ae = bus.adv_valid && !aok;
        if (acc) begin
            hist[m_wr] = bus.in_byte;
            m_wr++;
        end
        if (aok) begin
            m_cur  += int'(bus.adv_len);
            m_hist  = (m_hist + int'(bus.adv_len) > HMAX) ? HMAX : m_hist + int'(bus.adv_len);
        end
        if (m_phase == 2) begin
            m_phase = 0;
            m_hist  = 0;
        end else if (m_phase == 1 && look == 0) m_phase = 2;
        else if (m_phase == 0 && acc && bus.in_last) m_phase = 1;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        m_reset();
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            bus.in_valid = 1; bus.in_byte = s[i];
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        @(posedge clock);
        #1;
        vectors++;
        if (obs_all() !== 52'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want %h", obs_all(), 52'h0);
        end
        reset = 0;
        m_reset();
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || obs_all() !== exp_all()) begin
            miscompares++;
            $display("FAIL after_reset got %h want %h", obs_all(), exp_all());
        end
    endtask

    task automatic test_stream(input string name);
        string s;
        int    dones;
        bit    prev_done;
        s = "ABCABCABCX"; dones = 0; prev_done = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1; bus.in_byte = s[i]; bus.in_last = (i == 9);
            tick();
        end
        idle();
        vectors++;
        if ({bus.hash_valid, bus.hash_key, bus.hash_pos} !== {1'b1, 24'h414243, 12'h000}) begin
            miscompares++;
            $display("FAIL %s_hash0 got %h want %h", name,
                     {bus.hash_valid, bus.hash_key, bus.hash_pos}, {1'b1, 24'h414243, 12'h000});
        end
        for (int c = 0; c < 16; c++) begin
            bus.adv_valid = (m_look() > 0); bus.adv_len = 5'd1;
            tick();
            vectors++;
            if (obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL %s_drain c=%0d got %h want %h", name, c, obs_all(), exp_all());
            end
            if (m_phase == 1 && m_look() == 2) begin
                vectors++;
                if (bus.hash_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s_hash_drop got %b want 0", name, bus.hash_valid);
                end
            end
            if (prev_done) begin
                vectors++;
                if (bus.in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s_ready_after_done got %b want 1", name, bus.in_ready);
                end
            end
            prev_done = bus.done;
            dones += int'(bus.done);
        end
        idle();
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("FAIL %s_done_count got %0d want 1", name, dones);
        end
    endtask

    task automatic test_match();
        int offs [3];
        logic [6:0] want [3];
        do_reset();
        write_str("ABCABC");
        bus.adv_valid = 1; bus.adv_len = 5'd3;
        tick();
        idle();
        offs[0] = 3; offs[1] = 0; offs[2] = 4;
        want[0] = {1'b1, 5'd3, 1'b0}; want[1] = {1'b1, 5'd0, 1'b1}; want[2] = {1'b1, 5'd0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            bus.cmp_req = 1; bus.cmp_offset = 12'(offs[k]);
            tick();
            vectors++;
            if ({bus.cmp_valid, bus.cmp_len, bus.cmp_err} !== want[k] || obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL match_off%0d got %h want %h", offs[k], obs_all(), exp_all());
            end
        end
        idle();
        for (int k = 0; k < 2; k++) begin
            bus.adv_valid = 1; bus.adv_len = (k == 0) ? 5'd0 : 5'(m_look() + 1);
            tick();
            vectors++;
            if ({bus.adv_err, bus.hash_pos} !== {1'b1, 12'd3} || obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL adv_reject%0d got %h want %h", k, obs_all(), exp_all());
            end
        end
        idle();
    endtask

    task automatic test_overlap();
        do_reset();
        write_str("AAAAAAA");
        bus.adv_valid = 1; bus.adv_len = 5'd3;
        tick();
        idle();
        bus.cmp_req = 1; bus.cmp_offset = 12'd1;
        tick();
        idle();
        vectors++;
        if ({bus.cmp_valid, bus.cmp_len, bus.cmp_err} !== {1'b1, 5'd4, 1'b0} || obs_all() !== exp_all()) begin
            miscompares++;
            $display("FAIL overlap got %h want %h", obs_all(), exp_all());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1; bus.in_byte = 8'($urandom_range(0, 255));
            tick();
        end
        idle();
        vectors++;
        if ({bus.in_ready, bus.look_cnt} !== {1'b0, 5'd16} || obs_all() !== exp_all()) begin
            miscompares++;
            $display("FAIL backpressure_full got %h want %h", obs_all(), exp_all());
        end
        bus.adv_valid = 1; bus.adv_len = 5'd16;
        tick();
        idle();
        vectors++;
        if ({bus.in_ready, bus.look_cnt} !== {1'b1, 5'd0} || obs_all() !== exp_all()) begin
            miscompares++;
            $display("FAIL backpressure_release got %h want %h", obs_all(), exp_all());
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.in_byte    = 8'($urandom_range(65, 68));
            bus.in_last    = 0;
            bus.cmp_req    = 1;
            bus.cmp_offset = 12'($urandom_range(0, m_hist + 1));
            bus.adv_valid  = ($urandom_range(0, 2) == 0);
            bus.adv_len    = 5'($urandom_range(0, m_look() + 1));
            tick();
            vectors++;
            if (obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL back_to_back c=%0d got %h want %h", c, obs_all(), exp_all());
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        int cyc;
        do_reset();
        cyc = 0;
        while (m_wr < 10000 && cyc < 40000) begin
            bus.in_valid  = 1;
            bus.in_byte   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(48, 51)) : pattern[m_wr % HD];
            bus.adv_valid = (m_look() >= 4);
            bus.adv_len   = 5'($urandom_range(1, (m_look() > 0) ? m_look() : 1));
            bus.cmp_req   = 1;
            bus.cmp_offset = (m_hist == HMAX && $urandom_range(0, 1) == 1) ? 12'(HMAX)
                                                                          : 12'($urandom_range(0, m_hist));
            tick();
            cyc++;
            vectors++;
            if (obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL wrap c=%0d got %h want %h", cyc, obs_all(), exp_all());
            end
        end
        idle();
        vectors++;
        if (m_wr < 10000) begin
            miscompares++;
            $display("FAIL wrap_timeout got %0d bytes want 10000", m_wr);
        end
        bus.cmp_req = 1; bus.cmp_offset = 12'(HMAX);
        tick();
        vectors++;
        if ({bus.cmp_valid, bus.cmp_err} !== 2'b10 || obs_all() !== exp_all()) begin
            miscompares++;
            $display("FAIL wrap_off4080 got %h want %h", obs_all(), exp_all());
        end
        bus.cmp_offset = 12'(HMAX + 1);
        tick();
        vectors++;
        if ({bus.cmp_valid, bus.cmp_len, bus.cmp_err} !== {1'b1, 5'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_off4081 got %h want %h",
                     {bus.cmp_valid, bus.cmp_len, bus.cmp_err}, {1'b1, 5'd0, 1'b1});
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        write_str("QRSTUV");
        bus.cmp_req = 1; bus.cmp_offset = 12'd1;
        #3;
        reset = 1;
        #1;
        vectors++;
        if (obs_all() !== 52'h0) begin
            miscompares++;
            $display("FAIL midreset_async got %h want %h", obs_all(), 52'h0);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (obs_all() !== 52'h0) begin
            miscompares++;
            $display("FAIL midreset_no_cmp got %h want %h", obs_all(), 52'h0);
        end
        idle();
        reset = 0;
        m_reset();
        #1;
        test_stream("restream");
    endtask

    initial begin
        idle();
        m_reset();
        for (int i = 0; i < HD; i++) pattern[i] = 8'($urandom_range(48, 51));
        test_reset();
        test_stream("stream");
        test_match();
        test_overlap();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/history_window.md
Name: history_window

Overview:
- Parametrised sliding-window history and lookahead buffer for the LZRW1 compressor front end.
- Accepts the raw byte stream with a valid/ready handshake and stores it in a circular buffer that wraps at HIST_DEPTH.
- Presents a HASH_BYTES-byte hash key at the encode cursor and answers registered match-length queries against any past offset.
- Advances the cursor under encoder control; sits between the byte source and the hash/match encoder.

Parameters:
- HIST_DEPTH, 4096, ring size in bytes; must be a power of two.
- MAX_MATCH, 16, maximum lookahead and match length in bytes; must be < HIST_DEPTH/2.
- HASH_BYTES, 3, bytes per hash key; must be ≤ MAX_MATCH.
- POS_W, $clog2(HIST_DEPTH), pointer and offset width.
- LEN_W, $clog2(MAX_MATCH+1), length width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  buffer can accept a byte.
- in_byte  in  8  input byte.
- in_last  in  1  final byte of the stream.
- hash_valid  out  1  hash_key is valid.
- hash_key  out  8*HASH_BYTES  bytes cur..cur+HASH_BYTES-1; cur byte in the MSBs.
- hash_pos  out  POS_W  cursor ring index.
- cmp_req  in  1  match query strobe.
- cmp_offset  in  POS_W  match distance back from cur.
- cmp_valid  out  1  query result strobe.
- cmp_len  out  LEN_W  matched length.
- cmp_err  out  1  query offset was illegal.
- adv_valid  in  1  advance-cursor strobe.
- adv_len  in  LEN_W  number of bytes to consume.
- adv_err  out  1  advance was rejected.
- look_cnt  out  LEN_W  bytes not yet encoded.
- done  out  1  stream-end pulse.

Behaviour:
- State and pointers:
  - wr_ptr and cur are POS_W wide and wrap modulo HIST_DEPTH.
  - look_cnt = wr_ptr - cur, range 0..MAX_MATCH.
  - hist_cnt counts bytes behind cur and saturates at HIST_DEPTH-MAX_MATCH. Overwritten slots are never referenced.
- Reset values: pointers, counts and all strobes 0; hash_key 0; state RUN; in_ready 0 during reset, 1 on the first cycle after reset.
- Input handshake:
  - in_ready = (state==RUN) && (look_cnt < MAX_MATCH).
  - A byte is accepted when in_valid && in_ready; it is written at wr_ptr and wr_ptr increments.
  - in_valid is ignored while in_ready=0. Data is not required to hold.
- States:
  - RUN -> DRAIN when an accepted byte has in_last=1.
  - DRAIN -> DONE when look_cnt reaches 0.
  - DONE: done=1 for exactly one cycle; hist_cnt cleared. The history contents are not cleared, but are unreachable. Next state is RUN.
- Hash output (combinational from registered state):
  - hash_valid = look_cnt ≥ HASH_BYTES.
  - In DRAIN with look_cnt < HASH_BYTES, hash_valid=0; the encoder must emit literals.
- Match query, one-cycle latency:
  - cmp_req in cycle N -> cmp_valid in cycle N+1, using the cur and look_cnt values of cycle N.
  - cmp_len = number of leading i < look_cnt for which byte[cur-offset+i] == byte[cur+i], capped at MAX_MATCH.
  - Overlapping matches (offset < cmp_len) are legal; those candidate bytes come from lookahead.
  - Illegal query (offset==0 or offset>hist_cnt): cmp_len=0 and cmp_err=1 in cycle N+1.
  - Back-to-back queries give one result per cycle.
- Advance:
  - Accepted if 1 ≤ adv_len ≤ look_cnt; then cur += adv_len and hist_cnt += adv_len (saturating).
  - Rejected otherwise: no state change, adv_err pulses in the next cycle.
- Same-cycle events:
  - Byte write and advance in one cycle: both apply; look_cnt = old + 1 - adv_len.
  - cmp_req and adv_valid in one cycle: the query sees the pre-advance cursor.
  - A write to a slot being read as a candidate cannot occur, because the slot is beyond hist_cnt.
- Wrap-around: all index arithmetic is unsigned modulo HIST_DEPTH. No special case exists at pointer wrap.
- Reset mid-stream: all state is abandoned immediately. A pending cmp_valid does not fire.

Decomposition:
- Package lz_pkg holds:
  - HIST_DEPTH, MAX_MATCH and HASH_BYTES defaults;
  - the pos_t and len_t typedefs;
  - the window state enum {RUN, DRAIN, DONE}.
- Sub-module match_len_cmp: combinational MAX_MATCH-byte compare-and-priority-count. Inputs are two byte vectors and a limit; output is len. Its result is registered in history_window.

Test Plan:
- Reset, then stream "ABCABCABCX" with in_last on X; advance by 1 per byte -> hash_key 0x414243 at pos 0; hash_valid drops when look_cnt=2 in DRAIN; done pulses once; next cycle in_ready=1.
- After "ABCABC" with cur=3, cmp_offset=3 -> cmp_len=3 next cycle, cmp_err=0. With cur=3 and bytes "AAAAAAA", cmp_offset=1 -> overlapped cmp_len=4 (capped by look_cnt).
- cmp_offset=0, and cmp_offset=hist_cnt+1 -> cmp_len=0, cmp_err=1. adv_len=0 and adv_len=look_cnt+1 -> adv_err=1, cur unchanged.
- Hold in_valid high without advancing -> in_ready falls after 16 bytes, look_cnt=16; one adv_len=16 -> in_ready=1 the next cycle.
- Stream 10000 pseudo-random bytes with 4096-periodic repeats -> across wr_ptr wrap, a query at offset 4080 returns the correct length; hist_cnt saturates at 4080.
- Assert reset mid-stream with cmp_req pending -> no cmp_valid; all outputs at reset values; a fresh stream behaves as in scenario 1.
